bcd_updown_display: RTL
=======================

# bcd_updown_display

Parametrised N-digit BCD up/down counter with built-in rate prescaler and multiplexed seven-segment driver, running entirely on the board clock. Rate control uses single-cycle enable ticks, not derived clocks. Adds:
- synchronous parallel load,
- pause,
- wrap/saturate terminal behaviour,
- terminal-count pulse,
- leading-zero blanking.

It sits directly under the board top, between the switch/button inputs and the AN/SEG/LED pins.

## Interface
- DIGITS, 2, number of BCD digits (1..8)
- SCAN_BIT, 16, div_cnt bit whose rising edge advances the display scan
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked)

- clk  in  1  board clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rate_sel  in  5  selects div_cnt bit (0..31) whose rising edge produces a count tick
- en  in  1  1 = count on ticks, 0 = pause (hold value)
- dir  in  1  1 = up, 0 = down
- mode_sat  in  1  0 = wrap at terminal, 1 = saturate at terminal
- load  in  1  synchronous load strobe
- load_val  in  4*DIGITS  BCD value to load; digit 0 is in the LSBs
- bcd_out  out  4*DIGITS  current count, registered
- tc  out  1  one-cycle terminal-count pulse
- AN  out  8  anode enables, active-low; bits DIGITS..7 are always 1
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- **div_cnt**: 32-bit free-running counter, +1 every clk, wraps at 2^32.
- **Count tick**:
  - sel_d is the registered copy of div_cnt[rate_sel].
  - tick = div_cnt[rate_sel] & ~sel_d.
  - Tick period is 2^(rate_sel+1) clk cycles.
  - A rate_sel change may produce or drop at most one tick; there is no other glitch.
- **Count update priority**, each cycle:
  - **load = 1**: count <= load_val, with each digit >9 clamped to 9. tc = 0. Load does not need a tick and overrides en, tick and dir.
  - **Else tick & en, dir = 1**:
    - If count is all 9s: wrap to 0 (mode_sat = 0) or hold (mode_sat = 1), and assert tc.
    - Otherwise increment, digit 0 least significant, with per-digit carry 9 -> 0.
  - **Else tick & en, dir = 0**:
    - If count is 0: wrap to all 9s (mode_sat = 0) or hold (mode_sat = 1), and assert tc.
    - Otherwise decrement with per-digit borrow 0 -> 9.
  - **Otherwise**: hold; tc = 0.
- tc is registered, high for exactly one cycle per terminal tick. With saturation it pulses on every tick spent at the terminal value.
- dir and mode_sat are sampled only on tick cycles; a change takes effect on the next tick.
- **Scan**:
  - A scan tick is the rising edge of div_cnt[SCAN_BIT], edge-detected the same way as the count tick.
  - The scan index advances 0, 1, .., DIGITS-1, 0 on each scan tick.
  - With DIGITS = 1 the index stays 0.
- **Display**:
  - AN = ~(1 << index), with bits >= DIGITS forced to 1.
  - SEG is the active-low decode of count digit[index] (0..9).
  - With BLANK_LZ = 1, digit i (i > 0) shows SEG = 7'h7F if it and every higher digit are 0. AN still strobes for a blanked digit.

## Timing
- **Reset** (asynchronous, immediate): div_cnt = 0, sel_d = 0, scan index = 0, bcd_out = 0, tc = 0, AN = 8'hFF, SEG = 7'h7F. The first scan tick after reset restores normal AN/SEG.
- **Count latency**:
  - div_cnt[rate_sel] becomes 1 after edge k.
  - tick is true between edges k and k+1.
  - bcd_out and tc update at edge k+1.
- **Load latency**: load high before edge k gives bcd_out = load_val after edge k.
- **Display latency**: AN/SEG are registered and reflect index and bcd_out one cycle after either changes.
- **Reset mid-operation**:
  - All state clears at once, with no partial increment.
  - After release, div_cnt restarts at 0. The first tick occurs when div_cnt reaches 2^rate_sel, landing in bcd_out one cycle later.

## Test plan
- **Up count with decimal carry**: reset, rate_sel = 0, en = 1, dir = 1, DIGITS = 2 -> bcd_out goes 00, 01, .. 09, 10, one step every 2 clk; tc stays 0.
- **Wrap up and wrap down**:
  - Load 8'h98, dir = 1, mode_sat = 0 -> 99 then 00, with tc high for exactly the 00 cycle.
  - Load 8'h00, dir = 0 -> 99 with a tc pulse.
- **Saturate**:
  - mode_sat = 1, load 8'h99, dir = 1, 3 ticks -> bcd_out stays 99, tc pulses 3 times.
  - Same with dir = 0 from 00 -> stays 00.
- **Load priority and clamp**:
  - load = 1 with load_val = 8'hC5 on a tick cycle -> bcd_out = 8'h95 next cycle and no count step that cycle.
  - en = 0 -> bcd_out holds over 10 ticks.
- **Display and blanking** (SCAN_BIT = 2, DIGITS = 2, BLANK_LZ = 1):
  - count 07 -> AN alternates 8'hFE / 8'hFD. SEG = 7'b1111000 ("7") on digit 0 and 7'h7F on digit 1.
  - count 40 -> digit 0 shows "0" (7'b1000000), digit 1 shows "4" (7'b0011001).
- **Async reset mid-count**: assert rst_n = 0 between clock edges at count 37 -> bcd_out = 0, AN = 8'hFF, SEG = 7'h7F immediately. After release, the first increment lands at 2^rate_sel + 1 cycles.

Source files
------------

// File: rtl/bcd_updown_display_if.sv
// Control and display bundle for the BCD up/down counter.
// The board-side driver is the master; the counter block is the slave.
interface bcd_updown_display_if #(
    parameter int DIGITS = 2
);
    logic [4:0]          rate_sel;
    logic                en;
    logic                dir;
    logic                mode_sat;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] bcd_out;
    logic                tc;
    logic [7:0]          AN;
    logic [6:0]          SEG;

    modport master (
        output rate_sel, en, dir, mode_sat, load, load_val,
        input  bcd_out, tc, AN, SEG
    );

    modport slave (
        input  rate_sel, en, dir, mode_sat, load, load_val,
        output bcd_out, tc, AN, SEG
    );
endinterface

// File: rtl/bcd_updown_display.sv
// N-digit BCD up/down counter with tick prescaler, load, pause,
// wrap/saturate terminal handling and a multiplexed 7-seg driver.
module bcd_updown_display #(
    parameter int DIGITS   = 2,
    parameter int SCAN_BIT = 16,
    parameter int BLANK_LZ = 1
) (
    input logic                clk,
    input logic                rst_n,
    bcd_updown_display_if.slave bus
);
    logic [31:0]         div_cnt;
    logic                sel_d;
    logic                scan_d;
    logic                tick;
    logic                scan_tick;
    logic [4*DIGITS-1:0] cnt;
    logic [4*DIGITS-1:0] cnt_nxt;
    logic                tc_q;
    logic                tc_nxt;
    logic                all9;
    logic                all0;
    logic                cy;
    logic [2:0]          idx;
    logic                disp_on;
    logic [3:0]          cur;
    logic                blank;
    logic                zero_above;
    logic [7:0]          an_q;
    logic [7:0]          an_nxt;
    logic [6:0]          seg_q;
    logic [6:0]          seg_nxt;

    assign tick      = div_cnt[bus.rate_sel] & ~sel_d;
    assign scan_tick = div_cnt[SCAN_BIT] & ~scan_d;

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (cnt[4*i +: 4] != 4'd0) all0 = 1'b0;
        end
    end

    // Load beats counting; a terminal tick flags tc whether it wraps or holds.
    always_comb begin
        cnt_nxt = cnt;
        tc_nxt  = 1'b0;
        cy      = 1'b1;
        if (bus.load) begin
            for (int i = 0; i < DIGITS; i++) begin
                cnt_nxt[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ?
                                    4'd9 : bus.load_val[4*i +: 4];
            end
        end else if (tick && bus.en) begin
            if (bus.dir) begin
                if (all9) begin
                    tc_nxt = 1'b1;
                    if (!bus.mode_sat) cnt_nxt = '0;
                end else begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cy) begin
                            if (cnt[4*i +: 4] == 4'd9) begin
                                cnt_nxt[4*i +: 4] = 4'd0;
                            end else begin
                                cnt_nxt[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                                cy = 1'b0;
                            end
                        end
                    end
                end
            end else begin
                if (all0) begin
                    tc_nxt = 1'b1;
                    if (!bus.mode_sat) cnt_nxt = {DIGITS{4'd9}};
                end else begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cy) begin
                            if (cnt[4*i +: 4] == 4'd0) begin
                                cnt_nxt[4*i +: 4] = 4'd9;
                            end else begin
                                cnt_nxt[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
                                cy = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Walk from the top digit down so zero_above covers digit i and above.
    always_comb begin
        cur        = 4'd0;
        blank      = 1'b0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (cnt[4*i +: 4] == 4'd0);
            if (idx == 3'(i)) begin
                cur   = cnt[4*i +: 4];
                blank = (i > 0) && zero_above && (BLANK_LZ != 0);
            end
        end
    end

    always_comb begin
        an_nxt = 8'hFF;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == 3'(i)) an_nxt[i] = 1'b0;
        end
        unique case (cur)
            4'd0:    seg_nxt = 7'b1000000;
            4'd1:    seg_nxt = 7'b1111001;
            4'd2:    seg_nxt = 7'b0100100;
            4'd3:    seg_nxt = 7'b0110000;
            4'd4:    seg_nxt = 7'b0011001;
            4'd5:    seg_nxt = 7'b0010010;
            4'd6:    seg_nxt = 7'b0000010;
            4'd7:    seg_nxt = 7'b1111000;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0010000;
            default: seg_nxt = 7'h7F;
        endcase
        if (blank) seg_nxt = 7'h7F;
        if (!disp_on) begin
            an_nxt  = 8'hFF;
            seg_nxt = 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sel_d   <= 1'b0;
            scan_d  <= 1'b0;
            cnt     <= '0;
            tc_q    <= 1'b0;
            idx     <= 3'd0;
            disp_on <= 1'b0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
        end else begin
            div_cnt <= div_cnt + 32'd1;
            sel_d   <= div_cnt[bus.rate_sel];
            scan_d  <= div_cnt[SCAN_BIT];
            cnt     <= cnt_nxt;
            tc_q    <= tc_nxt;
            if (scan_tick) begin
                idx     <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
                disp_on <= 1'b1;
            end
            an_q    <= an_nxt;
            seg_q   <= seg_nxt;
        end
    end

    assign bus.bcd_out = cnt;
    assign bus.tc      = tc_q;
    assign bus.AN      = an_q;
    assign bus.SEG     = seg_q;
endmodule
